// File: rtl/bcd_mmss_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mmss_timer_if
//  Description : Control strobes and display/status outputs of the MM:SS BCD
//                timer, grouped as one bundle. The master drives the strobes
//                and levels; the slave (the timer) drives digits and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_mmss_timer_if;
  logic       tick_en;
  logic       adj_tick;
  logic       pause;
  logic       adj;
  logic       sel;
  logic       down;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       rollover;
  logic       at_limit;

  modport master (
    output tick_en, adj_tick, pause, adj, sel, down,
    input  min_tens, min_ones, sec_tens, sec_ones, running, rollover, at_limit
  );

  modport slave (
    input  tick_en, adj_tick, pause, adj, sel, down,
    output min_tens, min_ones, sec_tens, sec_ones, running, rollover, at_limit
  );
endinterface
`default_nettype wire

// File: rtl/bcd_mmss_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mmss_timer
//  Description : MM:SS BCD stopwatch/timer for a four-digit display. Counts
//                up or down on single-cycle tick strobes, wraps or saturates
//                at 00:00 / MAX_MIN:59, supports pause toggling and a
//                per-field adjust mode driven by a separate adjust strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_mmss_timer #(
  parameter int MAX_MIN = 59,
  parameter int WRAP    = 1
) (
  input  logic            clk,
  input  logic            rst,
  bcd_mmss_timer_if.slave bus
);

  // Minute limit split into its BCD digits at elaboration.
  localparam logic [3:0] c_max_tens = 4'(MAX_MIN / 10);
  localparam logic [3:0] c_max_ones = 4'(MAX_MIN % 10);

  logic [3:0] r_min_tens;
  logic [3:0] r_min_ones;
  logic [3:0] r_sec_tens;
  logic [3:0] r_sec_ones;
  logic       r_running;
  logic       r_rollover;

  logic [3:0] w_min_tens;
  logic [3:0] w_min_ones;
  logic [3:0] w_sec_tens;
  logic [3:0] w_sec_ones;
  logic       w_rollover;

  logic       w_min_at_max;
  logic       w_sec_at_max;
  logic       w_at_top;
  logic       w_at_zero;
  logic       w_at_dir_limit;

  assign w_min_at_max   = (r_min_tens == c_max_tens) && (r_min_ones == c_max_ones);
  assign w_sec_at_max   = (r_sec_tens == 4'd5) && (r_sec_ones == 4'd9);
  assign w_at_top       = w_min_at_max && w_sec_at_max;
  assign w_at_zero      = (r_min_tens == 4'd0) && (r_min_ones == 4'd0) &&
                          (r_sec_tens == 4'd0) && (r_sec_ones == 4'd0);
  // The relevant limit follows the live direction input, so flipping down
  // at a limit is reflected without waiting for a tick.
  assign w_at_dir_limit = bus.down ? w_at_zero : w_at_top;

  // Next-value logic: adjust mode first, then counting, otherwise hold.
  always_comb begin
    w_min_tens = r_min_tens;
    w_min_ones = r_min_ones;
    w_sec_tens = r_sec_tens;
    w_sec_ones = r_sec_ones;
    w_rollover = 1'b0;

    if (bus.adj) begin
      if (bus.adj_tick) begin
        if (bus.sel) begin
          // Seconds field wraps 59 -> 00 without touching minutes.
          if (r_sec_ones == 4'd9) begin
            w_sec_ones = 4'd0;
            w_sec_tens = (r_sec_tens == 4'd5) ? 4'd0 : r_sec_tens + 4'd1;
          end else begin
            w_sec_ones = r_sec_ones + 4'd1;
          end
        end else begin
          if (w_min_at_max) begin
            w_min_tens = 4'd0;
            w_min_ones = 4'd0;
          end else if (r_min_ones == 4'd9) begin
            w_min_ones = 4'd0;
            w_min_tens = r_min_tens + 4'd1;
          end else begin
            w_min_ones = r_min_ones + 4'd1;
          end
        end
      end
    end else if (r_running && bus.tick_en) begin
      if (w_at_dir_limit) begin
        // At the limit: either jump to the opposite end or hold.
        if (WRAP != 0) begin
          w_rollover = 1'b1;
          if (bus.down) begin
            w_min_tens = c_max_tens;
            w_min_ones = c_max_ones;
            w_sec_tens = 4'd5;
            w_sec_ones = 4'd9;
          end else begin
            w_min_tens = 4'd0;
            w_min_ones = 4'd0;
            w_sec_tens = 4'd0;
            w_sec_ones = 4'd0;
          end
        end
      end else if (bus.down) begin
        // Borrow chain; not at 00:00, so minutes never underflow.
        if (r_sec_ones != 4'd0) begin
          w_sec_ones = r_sec_ones - 4'd1;
        end else begin
          w_sec_ones = 4'd9;
          if (r_sec_tens != 4'd0) begin
            w_sec_tens = r_sec_tens - 4'd1;
          end else begin
            w_sec_tens = 4'd5;
            if (r_min_ones != 4'd0) begin
              w_min_ones = r_min_ones - 4'd1;
            end else begin
              w_min_ones = 4'd9;
              w_min_tens = r_min_tens - 4'd1;
            end
          end
        end
      end else begin
        // Carry chain; not at MAX_MIN:59, so minutes never pass the limit.
        if (r_sec_ones != 4'd9) begin
          w_sec_ones = r_sec_ones + 4'd1;
        end else begin
          w_sec_ones = 4'd0;
          if (r_sec_tens != 4'd5) begin
            w_sec_tens = r_sec_tens + 4'd1;
          end else begin
            w_sec_tens = 4'd0;
            if (r_min_ones != 4'd9) begin
              w_min_ones = r_min_ones + 4'd1;
            end else begin
              w_min_ones = 4'd0;
              w_min_tens = r_min_tens + 4'd1;
            end
          end
        end
      end
    end
  end

  // State registers; pause toggles the run flag regardless of mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_min_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_sec_ones <= 4'd0;
      r_running  <= 1'b1;
      r_rollover <= 1'b0;
    end else begin
      r_min_tens <= w_min_tens;
      r_min_ones <= w_min_ones;
      r_sec_tens <= w_sec_tens;
      r_sec_ones <= w_sec_ones;
      r_running  <= r_running ^ bus.pause;
      r_rollover <= w_rollover;
    end
  end

  assign bus.min_tens = r_min_tens;
  assign bus.min_ones = r_min_ones;
  assign bus.sec_tens = r_sec_tens;
  assign bus.sec_ones = r_sec_ones;
  assign bus.running  = r_running;
  assign bus.rollover = r_rollover;
  assign bus.at_limit = (WRAP == 0) ? w_at_dir_limit : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_bcd_mmss_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_mmss_timer
//  Description : Self-checking bench for bcd_mmss_timer. Two instances run
//                side by side on identical stimulus: A (MAX_MIN=59, WRAP=1)
//                and B (MAX_MIN=5, WRAP=0). A reference model keeps each
//                count as a plain number of seconds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_mmss_timer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bcd_mmss_timer_if ifa ();
  bcd_mmss_timer_if ifb ();

  bcd_mmss_timer #(.MAX_MIN(59), .WRAP(1)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
  bcd_mmss_timer #(.MAX_MIN(5),  .WRAP(0)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int errors = 0;
  int checks = 0;

  // Reference model state: total seconds, run flag, rollover pulse.
  int tot [2];
  bit run [2];
  bit rov [2];

  // Observed vector layout: {mt, mo, st, so, running, rollover, at_limit}.
  localparam logic [18:0] c_m_digits = 19'h7fff8;
  localparam logic [18:0] c_m_all    = 19'h7ffff;

  function automatic int maxm(input int k);
    return (k == 0) ? 59 : 5;
  endfunction

  function automatic bit wrap(input int k);
    return (k == 0);
  endfunction

  function automatic logic [18:0] mk(input int mm, input int ss, input bit r, input bit ro, input bit al);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), r, ro, al};
  endfunction

  function automatic logic [18:0] obs_vec(input int k);
    if (k == 0)
      return {ifa.min_tens, ifa.min_ones, ifa.sec_tens, ifa.sec_ones,
              ifa.running, ifa.rollover, ifa.at_limit};
    return {ifb.min_tens, ifb.min_ones, ifb.sec_tens, ifb.sec_ones,
            ifb.running, ifb.rollover, ifb.at_limit};
  endfunction

  function automatic logic [18:0] exp_vec(input int k, input bit d);
    int  top;
    bit  lim;
    top = maxm(k) * 60 + 59;
    lim = !wrap(k) && (tot[k] == (d ? 0 : top));
    return mk(tot[k] / 60, tot[k] % 60, run[k], rov[k], lim);
  endfunction

  task automatic model_update(input int k, input bit r, input bit t, input bit at,
                              input bit p, input bit a, input bit s, input bit d);
    int top;
    int m;
    int sc;
    bit old_run;
    top     = maxm(k) * 60 + 59;
    old_run = run[k];
    if (r) begin
      tot[k] = 0;
      run[k] = 1'b1;
      rov[k] = 1'b0;
    end else begin
      rov[k] = 1'b0;
      if (p) run[k] = !run[k];
      if (a) begin
        if (at) begin
          m  = tot[k] / 60;
          sc = tot[k] % 60;
          if (s) sc = (sc + 1) % 60;
          else   m  = (m == maxm(k)) ? 0 : m + 1;
          tot[k] = m * 60 + sc;
        end
      end else if (old_run && t) begin
        if (!d && tot[k] == top) begin
          if (wrap(k)) begin tot[k] = 0; rov[k] = 1'b1; end
        end else if (d && tot[k] == 0) begin
          if (wrap(k)) begin tot[k] = top; rov[k] = 1'b1; end
        end else begin
          tot[k] = d ? tot[k] - 1 : tot[k] + 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [18:0] o,
                     input logic [18:0] e, input logic [18:0] mask);
    checks++;
    assert ((o & mask) === (e & mask)) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%05h expected=%05h", tag, k, o & mask, e & mask);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, check 1 ns later.
  task automatic step(input string tag, input bit r, input bit t, input bit at,
                      input bit p, input bit a, input bit s, input bit d);
    rst = r;
    ifa.tick_en = t; ifa.adj_tick = at; ifa.pause = p; ifa.adj = a; ifa.sel = s; ifa.down = d;
    ifb.tick_en = t; ifb.adj_tick = at; ifb.pause = p; ifb.adj = a; ifb.sel = s; ifb.down = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k, r, t, at, p, a, s, d);
    #1;
    for (int k = 0; k < 2; k++) chk(tag, k, obs_vec(k), exp_vec(k, d), c_m_all);
  endtask

  initial begin
    // Reset state.
    step("reset", 1, 0, 0, 0, 0, 0, 0);
    chk("reset_val", 0, obs_vec(0), mk(0, 0, 1, 0, 0), c_m_all);
    chk("reset_val", 1, obs_vec(1), mk(0, 0, 1, 0, 0), c_m_all);

    // 600 up ticks from reset; 09:59 -> 10:00 carries across all digits.
    for (int i = 0; i < 600; i++) step("up600", 0, 1, 0, 0, 0, 0, 0);
    chk("up600_val", 0, obs_vec(0), mk(10, 0, 1, 0, 0), c_m_all);

    // Preset 59:59 through adjust (with overlapping tick_en), then wrap up and down.
    step("rst2", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 59; i++) step("adj_min", 0, (i % 3) == 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 59; i++) step("adj_sec", 0, (i % 4) == 0, 1, 0, 1, 1, 0);
    chk("preset_5959", 0, obs_vec(0), mk(59, 59, 1, 0, 0), c_m_digits);
    step("leave_adj", 0, 0, 0, 0, 0, 0, 0);
    step("wrap_up", 0, 1, 0, 0, 0, 0, 0);
    chk("wrap_up_val", 0, obs_vec(0), mk(0, 0, 1, 1, 0), c_m_all);
    step("wrap_up_idle", 0, 0, 0, 0, 0, 0, 0);
    chk("rollover_1cyc", 0, obs_vec(0), mk(0, 0, 1, 0, 0), c_m_all);
    step("wrap_dn", 0, 1, 0, 0, 0, 0, 1);
    chk("wrap_dn_val", 0, obs_vec(0), mk(59, 59, 1, 1, 0), c_m_all);
    step("wrap_dn_idle", 0, 0, 0, 0, 0, 0, 1);

    // Saturation on B: count to 05:59, extra ticks hold, flip direction.
    step("rst3", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 359; i++) step("sat_up", 0, 1, 0, 0, 0, 0, 0);
    chk("sat_reach", 1, obs_vec(1), mk(5, 59, 1, 0, 1), c_m_all);
    for (int i = 0; i < 3; i++) step("sat_hold", 0, 1, 0, 0, 0, 0, 0);
    chk("sat_held", 1, obs_vec(1), mk(5, 59, 1, 0, 1), c_m_all);
    step("sat_flip", 0, 0, 0, 0, 0, 0, 1);
    chk("sat_flip_lim", 1, obs_vec(1), mk(5, 59, 1, 0, 0), c_m_all);
    step("sat_away", 0, 1, 0, 0, 0, 0, 1);
    chk("sat_away_val", 1, obs_vec(1), mk(5, 58, 1, 0, 0), c_m_all);

    // Adjust fields: 12:59 -> 12:00 (no carry), 59:00 -> 00:00.
    step("rst4", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step("adj12", 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 59; i++) step("adj59s", 0, 0, 1, 0, 1, 1, 0);
    chk("adj_1259", 0, obs_vec(0), mk(12, 59, 1, 0, 0), c_m_digits);
    step("adj_secwrap", 0, 1, 1, 0, 1, 1, 0);
    chk("adj_secwrap_val", 0, obs_vec(0), mk(12, 0, 1, 0, 0), c_m_all);
    for (int i = 0; i < 47; i++) step("adj_to59", 0, 0, 1, 0, 1, 0, 0);
    step("adj_minwrap", 0, 0, 1, 0, 1, 0, 0);
    chk("adj_minwrap_val", 0, obs_vec(0), mk(0, 0, 1, 0, 0), c_m_all);
    for (int i = 0; i < 5; i++) step("adj_tick_ign", 0, 1, 0, 0, 1, 0, 0);

    // Pause toggling.
    step("pause_on", 0, 0, 0, 1, 0, 0, 0);
    chk("paused", 0, obs_vec(0), mk(0, 0, 0, 0, 0), c_m_all);
    for (int i = 0; i < 5; i++) step("paused_tick", 0, 1, 0, 0, 0, 0, 0);
    step("pause_off", 0, 0, 0, 1, 0, 0, 0);
    step("resume_tick", 0, 1, 0, 0, 0, 0, 0);
    chk("resume_val", 0, obs_vec(0), mk(0, 1, 1, 0, 0), c_m_all);

    // Pause while preset to 33:33, then reset together with tick and pause.
    for (int i = 0; i < 33; i++) step("adj33m", 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 32; i++) step("adj33s", 0, 0, 1, 0, 1, 1, 0);
    step("pause_again", 0, 0, 0, 1, 0, 0, 0);
    chk("at_3333", 0, obs_vec(0), mk(33, 33, 0, 0, 0), c_m_all);
    step("rst_combo", 1, 1, 0, 1, 0, 0, 0);
    chk("rst_combo_val", 0, obs_vec(0), mk(0, 0, 1, 0, 0), c_m_all);

    // Randomised traffic against the model.
    begin
      bit d_lvl;
      bit a_lvl;
      bit s_lvl;
      d_lvl = 1'b0;
      a_lvl = 1'b0;
      s_lvl = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 30) == 0) d_lvl = !d_lvl;
        if ($urandom_range(0, 25) == 0) a_lvl = !a_lvl;
        if ($urandom_range(0, 10) == 0) s_lvl = !s_lvl;
        step("random", $urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
             a_lvl, s_lvl, d_lvl);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
